sbqm_queue_counter: RTL
=======================

Name: sbqm_queue_counter

Overview:
- Front end of the Smart Bank queue Manager (SBqM).
- Qualifies the two photocell beam sensors: the back sensor marks a customer entering and the front sensor marks a customer leaving toward a teller.
- Maintains the saturating 3-bit people count.
- Registers the 5-bit waiting-time lookup address {tcount, pcount} that the waiting-time table consumes, together with full/empty flags for the display.

Parameters:
- MIN_HOLD, 4: consecutive synchronized high samples required before a beam break is accepted (legal range 2..15).
- MAX_COUNT, 7: saturation value of pcount; must be at most 2**PCOUNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- back_sensor  in  1  raw entry photocell, 1 = beam blocked, asynchronous to clk.
- front_sensor  in  1  raw exit photocell, 1 = beam blocked, asynchronous to clk.
- tcount_in  in  2  number of active tellers minus one, from switches, quasi-static.
- pcount  out  3  registered people count.
- tcount  out  2  registered copy of tcount_in.
- wt_addr  out  5  registered {tcount, pcount}, the waiting-time table address.
- addr_valid  out  1  one-cycle pulse when wt_addr changes.
- full  out  1  pcount == MAX_COUNT.
- empty  out  1  pcount == 0.

Behaviour:
- Reset: rst_n is asynchronous and active-low.
  - pcount=0, tcount=0, wt_addr=0, addr_valid=0, full=0, empty=1.
  - Synchronizers are cleared to 0 and both qualifier FSMs return to IDLE.
- Synchronization: each sensor passes through a 2-flop synchronizer; the result is sensor_s.
- Qualifier FSM, one instance per sensor:
  - IDLE: sensor_s=1 moves to QUAL and loads hold_cnt=1.
  - QUAL: sensor_s=0 returns to IDLE with no event (glitch rejected). sensor_s=1 increments hold_cnt; when hold_cnt reaches MIN_HOLD the FSM moves to HELD.
  - HELD: sensor_s=0 returns to IDLE and emits a 1-cycle pass pulse. sensor_s=1 stays in HELD; a long block produces no extra events.
- Event timing: a customer is counted only after the beam has been blocked and then released (trailing edge). pass is registered and asserts 3 cycles after the raw sensor falls.
- Count update, in the cycle after the pass pulses:
  - inc only: pcount+1, saturating at MAX_COUNT. An entry while full is dropped.
  - dec only: pcount-1, saturating at 0. An exit while empty is dropped.
  - inc and dec in the same cycle: pcount unchanged.
  - No wrap-around in either direction.
- tcount: sampled from tcount_in every cycle. tcount_in must be stable for 2 cycles; no extra synchronizer is required.
- Address: wt_addr={tcount, pcount} is registered.
  - addr_valid pulses for exactly 1 cycle whenever the new wt_addr differs from the previous value.
  - No pulse when a saturated or cancelled event leaves the address unchanged.
- Flags: full and empty are decoded from the registered pcount, with no added latency relative to pcount.
- Reset mid-operation: all state is cleared immediately; a beam still blocked at rst_n release must first be qualified from IDLE.

Optional Feature:
- Macro: SBQM_SATURATE_ERR_EN.
- Defined:
  - Adds input err_clr (1) and output sat_err (1).
  - sat_err is set in the cycle after a dropped entry (inc while full) or dropped exit (dec while empty).
  - sat_err is sticky until err_clr=1; err_clr wins over a simultaneous set.
  - sat_err resets to 0.
- Undefined: the ports are absent and dropped events are silent.

Decomposition:
- Package sbqm_pkg:
  - PCOUNT_W=3 and TCOUNT_W=2.
  - ADDR_W=PCOUNT_W+TCOUNT_W.
  - Enum qual_state_t {IDLE, QUAL, HELD}.
- Sub-module sbqm_sensor_qual, instantiated twice:
  - Contains the synchronizer, hold counter and qualifier FSM.
  - Ports: clk, rst_n, sensor_raw, pass.
  - Parameter: MIN_HOLD.
- Top level holds the counter, the tcount register, address generation and the optional error logic.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> pcount=0, empty=1, full=0, wt_addr=5'b00000, addr_valid never pulses.
- Glitch rejection: back_sensor high for 3 cycles (MIN_HOLD=4) then low -> pcount stays 0. Repeat high for 6 cycles then low -> pcount=1 and wt_addr=5'b00001, with addr_valid pulsing once 4 cycles after the fall (3-cycle pass latency plus 1-cycle count update).
- Fill and saturate: tcount_in=2'b10, 9 qualified entries -> pcount=7, full=1, wt_addr=5'b10111. The 8th and 9th entries produce no addr_valid; with SBQM_SATURATE_ERR_EN, sat_err=1 until err_clr.
- Drain below empty: from pcount=2, 3 qualified exits -> pcount=0, empty=1, the third exit is dropped, 2 addr_valid pulses in total.
- Simultaneous events: pcount=3, front and back released on the same cycle -> pcount stays 3 and no addr_valid pulse.
- Async reset mid-block: assert rst_n low while back_sensor is in HELD, release with back_sensor still high, then drop it -> no count. The next full block/release cycle is counted.

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared widths, qualifier state encoding and address payload for the SBqM front end.
package sbqm_pkg;

    localparam int unsigned PCOUNT_W = 3;
    localparam int unsigned TCOUNT_W = 2;
    localparam int unsigned ADDR_W   = PCOUNT_W + TCOUNT_W;
    localparam int unsigned HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HELD = 2'd2
    } qual_state_t;

    // Waiting-time table address: teller count in the upper bits.
    typedef struct packed {
        logic [TCOUNT_W-1:0] tcount;
        logic [PCOUNT_W-1:0] pcount;
    } wt_addr_t;

endpackage

// File: rtl/sbqm_sensor_qual.sv
// Photocell qualifier: 2-flop synchronizer, hold counter and IDLE/QUAL/HELD FSM.
// A beam break must be seen high for MIN_HOLD consecutive synchronized samples;
// the pass pulse is emitted on the trailing edge (beam released).
module sbqm_sensor_qual
    import sbqm_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic pass
);

    logic              sync1;
    logic              sensor_s;
    qual_state_t       state;
    qual_state_t       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              pass_nxt;

    // Bring the asynchronous sensor into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sensor_s <= 1'b0;
        end else begin
            sync1    <= sensor_raw;
            sensor_s <= sync1;
        end
    end

    // Qualifier state, hold counter and registered pass pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            pass     <= pass_nxt;
        end
    end

    // Next-state: reject short blocks, fire once on release of a held block.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pass_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_s) begin
                    state_nxt = QUAL;
                    hold_nxt  = HOLD_W'(1);
                end
            end
            QUAL: begin
                if (!sensor_s) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                    if ((hold_cnt + HOLD_W'(1)) == HOLD_W'(MIN_HOLD)) begin
                        state_nxt = HELD;
                    end
                end
            end
            HELD: begin
                if (!sensor_s) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    pass_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/sbqm_queue_counter.sv
// SBqM front end: qualifies entry/exit photocells, keeps the saturating
// people count and registers the waiting-time table address and flags.
// Optional macro SBQM_SATURATE_ERR_EN adds err_clr / sticky sat_err.
module sbqm_queue_counter
    import sbqm_pkg::*;
#(
    parameter int unsigned MIN_HOLD  = 4,
    parameter int unsigned MAX_COUNT = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                back_sensor,
    input  logic                front_sensor,
    input  logic [TCOUNT_W-1:0] tcount_in,
`ifdef SBQM_SATURATE_ERR_EN
    input  logic                err_clr,
    output logic                sat_err,
`endif
    output logic [PCOUNT_W-1:0] pcount,
    output logic [TCOUNT_W-1:0] tcount,
    output logic [ADDR_W-1:0]   wt_addr,
    output logic                addr_valid,
    output logic                full,
    output logic                empty
);

    localparam logic [PCOUNT_W-1:0] MAX_P = PCOUNT_W'(MAX_COUNT);

    logic                inc;
    logic                dec;
    logic [PCOUNT_W-1:0] pcount_nxt;
    wt_addr_t            addr_nxt;

    // Entry sensor (back) qualifier.
    sbqm_sensor_qual #(
        .MIN_HOLD (MIN_HOLD)
    ) u_back_qual (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (back_sensor),
        .pass       (inc)
    );

    // Exit sensor (front) qualifier.
    sbqm_sensor_qual #(
        .MIN_HOLD (MIN_HOLD)
    ) u_front_qual (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (front_sensor),
        .pass       (dec)
    );

    // Saturating count update; simultaneous entry and exit cancel.
    always_comb begin
        pcount_nxt = pcount;
        if (inc && !dec) begin
            if (pcount != MAX_P) begin
                pcount_nxt = pcount + PCOUNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (pcount != '0) begin
                pcount_nxt = pcount - PCOUNT_W'(1);
            end
        end
    end

    // Next table address built from the values being registered this cycle.
    always_comb begin
        addr_nxt        = '0;
        addr_nxt.tcount = tcount_in;
        addr_nxt.pcount = pcount_nxt;
    end

    // Count, teller copy, address, change pulse and flags, all in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcount     <= '0;
            tcount     <= '0;
            wt_addr    <= '0;
            addr_valid <= 1'b0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            pcount     <= pcount_nxt;
            tcount     <= tcount_in;
            wt_addr    <= addr_nxt;
            addr_valid <= (ADDR_W'(addr_nxt) != wt_addr);
            full       <= (pcount_nxt == MAX_P);
            empty      <= (pcount_nxt == '0);
        end
    end

`ifdef SBQM_SATURATE_ERR_EN
    logic drop_c;

    // A dropped event is an entry while full or an exit while empty.
    always_comb begin
        drop_c = ((inc && !dec) && (pcount == MAX_P)) ||
                 ((dec && !inc) && (pcount == '0));
    end

    // Sticky saturation error; clear has priority over a new drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_err <= 1'b0;
        end else if (err_clr) begin
            sat_err <= 1'b0;
        end else if (drop_c) begin
            sat_err <= 1'b1;
        end
    end
`endif

endmodule
